// File: rtl/instruction_decode.sv
// Decode stage of the 16-bit pipelined core.
// Splits the fetched instruction into fields, reads the register file with
// write-back bypass, registers everything bound for Execute and stalls fetch
// for one cycle when an instruction needs the result of the load just ahead of it.
module instruction_decode #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic [DATA_W-1:0]  npc_in,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [4:0]         wb_index,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [4:0]         control_out,
    output logic [4:0]         dest_index_in,
    output logic [DATA_W-1:0]  reg1_data,
    output logic [DATA_W-1:0]  reg2_data,
    output logic [DATA_W-1:0]  npc,
    output logic [6:0]         immediate,
    output logic               valid_out,
    output logic               stall
);

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_SUB  = 5'd1,
        OP_ADD  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_XOR  = 5'd5,
        OP_ADDI = 5'd6,
        OP_LW   = 5'd7,
        OP_SW   = 5'd8,
        OP_BEQ  = 5'd9,
        OP_JMP  = 5'd10
    } opcode_t;

    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        imm;
    logic              unused_bits;
    logic              is_defined;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] regs [NREGS];

    assign opcode      = instr[31:27];
    assign rd          = instr[26:22];
    assign rs1         = instr[21:17];
    assign rs2         = instr[16:12];
    assign imm         = instr[6:0];
    assign unused_bits = ^instr[11:7];

    // Classify the opcode: which source registers it really reads, and whether it exists at all
    always_comb begin
        is_defined = (opcode <= OP_JMP);
        uses_rs1   = is_defined && (opcode != OP_NOP) && (opcode != OP_JMP);
        uses_rs2   = (opcode == OP_SUB) || (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_OR)  || (opcode == OP_XOR) || (opcode == OP_SW)  ||
                     (opcode == OP_BEQ);
    end

    // Register file write port; R0 is never written so it always reads as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_index != 5'd0)) begin
            regs[wb_index] <= wb_data;
        end
    end

    // Register file read ports with same-cycle bypass from the write-back port
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb_en && (wb_index == rs1)) ? wb_data : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (wb_en && (wb_index == rs2)) ? wb_data : regs[rs2];
        end
    end

    // Load-use hazard against the load sitting in the Execute-bound registers; a flush overrides it
    always_comb begin
        stall = 1'b0;
        if (!reset && !flush && instr_valid && valid_out &&
            (control_out == OP_LW) && (dest_index_in != 5'd0)) begin
            stall = (uses_rs1 && (rs1 == dest_index_in)) ||
                    (uses_rs2 && (rs2 == dest_index_in));
        end
    end

    // Execute-bound pipeline register: latch a decoded instruction or insert an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset || flush || stall || !instr_valid || !is_defined) begin
            control_out   <= 5'd0;
            dest_index_in <= 5'd0;
            reg1_data     <= '0;
            reg2_data     <= '0;
            npc           <= '0;
            immediate     <= 7'd0;
            valid_out     <= 1'b0;
        end else begin
            control_out   <= opcode;
            dest_index_in <= rd;
            reg1_data     <= rs1_val;
            reg2_data     <= rs2_val;
            npc           <= npc_in;
            immediate     <= imm;
            valid_out     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the decode stage.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] npc_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_index;
    logic [15:0] wb_data;
    logic [4:0]  control_out;
    logic [4:0]  dest_index_in;
    logic [15:0] reg1_data;
    logic [15:0] reg2_data;
    logic [15:0] npc;
    logic [6:0]  immediate;
    logic        valid_out;
    logic        stall;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [15:0] m_reg [32];
    logic [4:0]  m_ctrl;
    logic [4:0]  m_dest;
    logic [15:0] m_r1;
    logic [15:0] m_r2;
    logic [15:0] m_npc;
    logic [6:0]  m_imm;
    logic        m_valid;
    logic        last_stall;
    logic        obs_stall;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .npc_in(npc_in), .flush(flush), .wb_en(wb_en), .wb_index(wb_index),
        .wb_data(wb_data), .control_out(control_out), .dest_index_in(dest_index_in),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .npc(npc),
        .immediate(immediate), .valid_out(valid_out), .stall(stall)
    );

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        logic [4:0] o = op[4:0];
        logic [4:0] d = rd[4:0];
        logic [4:0] a = rs1[4:0];
        logic [4:0] b = rs2[4:0];
        logic [6:0] i = imm[6:0];
        return {o, d, a, b, 5'b0, i};
    endfunction

    // Opcode numbers: NOP 0 SUB 1 ADD 2 AND 3 OR 4 XOR 5 ADDI 6 LW 7 SW 8 BEQ 9 JMP 10
    function automatic bit reads_rs1(input int op);
        return (op >= 1) && (op <= 9);
    endfunction

    function automatic bit reads_rs2(input int op);
        return (op >= 1 && op <= 5) || op == 8 || op == 9;
    endfunction

    function automatic logic [15:0] model_read(input int idx, input logic we,
                                               input int wi, input logic [15:0] wd);
        if (idx == 0) return 16'd0;
        if (we && wi == idx) return wd;
        return m_reg[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("control_out", {27'd0, control_out}, {27'd0, m_ctrl});
        chk("dest_index_in", {27'd0, dest_index_in}, {27'd0, m_dest});
        chk("reg1_data", {16'd0, reg1_data}, {16'd0, m_r1});
        chk("reg2_data", {16'd0, reg2_data}, {16'd0, m_r2});
        chk("npc", {16'd0, npc}, {16'd0, m_npc});
        chk("immediate", {25'd0, immediate}, {25'd0, m_imm});
        chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
    endtask

    // One clock of stimulus: check stall before the edge, advance the model, check outputs after it
    task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] ins,
                                 input logic [15:0] pc, input logic fl, input logic we,
                                 input logic [4:0] wi, input logic [15:0] wd);
        int op, rd, a, b;
        logic exp_stall;
        reset = rst; instr_valid = iv; instr = ins; npc_in = pc;
        flush = fl; wb_en = we; wb_index = wi; wb_data = wd;
        op = int'(ins[31:27]); rd = int'(ins[26:22]);
        a  = int'(ins[21:17]); b  = int'(ins[16:12]);
        exp_stall = !rst && !fl && iv && m_valid && m_ctrl == 5'd7 && m_dest != 0 &&
                    ((reads_rs1(op) && a == int'(m_dest)) || (reads_rs2(op) && b == int'(m_dest)));
        #1;
        obs_stall = stall;
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        last_stall = exp_stall;
        if (rst || fl || exp_stall || !iv || op > 10) begin
            m_ctrl = 0; m_dest = 0; m_r1 = 0; m_r2 = 0; m_npc = 0; m_imm = 0; m_valid = 0;
        end else begin
            m_ctrl = ins[31:27]; m_dest = ins[26:22];
            m_r1 = model_read(a, we, int'(wi), wd);
            m_r2 = model_read(b, we, int'(wi), wd);
            m_npc = pc; m_imm = ins[6:0]; m_valid = 1'b1;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 16'd0;
        end else if (we && wi != 0) begin
            m_reg[wi] = wd;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] r_ins;
        logic [15:0] r_pc;
        for (int i = 0; i < 32; i++) m_reg[i] = 16'hxxxx;
        m_ctrl = 0; m_dest = 0; m_r1 = 0; m_r2 = 0; m_npc = 0; m_imm = 0; m_valid = 0;
        last_stall = 0;

        // Reset for two cycles
        applyStimulus(1, 1, mk(2, 4, 1, 2, 5), 16'h0040, 0, 1, 5'd3, 16'hBEEF);
        applyStimulus(1, 0, 32'd0, 16'd0, 0, 0, 5'd0, 16'd0);
        chk("reset_valid", {31'd0, valid_out}, 32'd0);

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            applyStimulus(0, 1, mk(2, 1, i, 32 - i, 0), 16'(i), 0, 0, 5'd0, 16'd0);
            chk("post_reset_r1", {16'd0, reg1_data}, 32'd0);
        end

        // SUB decode after write-backs of R1=10 and R2=3
        applyStimulus(0, 0, 32'd0, 16'd0, 0, 1, 5'd1, 16'd10);
        applyStimulus(0, 0, 32'd0, 16'd0, 0, 1, 5'd2, 16'd3);
        applyStimulus(0, 1, mk(1, 2, 1, 2, 0), 16'h0100, 0, 0, 5'd0, 16'd0);
        chk("sub_ctrl", {27'd0, control_out}, 32'd1);
        chk("sub_dest", {27'd0, dest_index_in}, 32'd2);
        chk("sub_r1", {16'd0, reg1_data}, 32'd10);
        chk("sub_r2", {16'd0, reg2_data}, 32'd3);
        chk("sub_valid", {31'd0, valid_out}, 32'd1);

        // Same-cycle write-back bypass
        applyStimulus(0, 1, mk(2, 6, 5, 0, 0), 16'h0102, 0, 1, 5'd5, 16'h1234);
        chk("bypass_r1", {16'd0, reg1_data}, 32'h1234);

        // Writes to R0 are dropped
        applyStimulus(0, 0, 32'd0, 16'd0, 0, 1, 5'd0, 16'hFFFF);
        applyStimulus(0, 1, mk(2, 6, 0, 1, 0), 16'h0104, 0, 0, 5'd0, 16'd0);
        chk("r0_read", {16'd0, reg1_data}, 32'd0);

        // Load-use: one stall cycle, one bubble, then the ADD issues
        applyStimulus(0, 1, mk(7, 3, 1, 0, 4), 16'h0106, 0, 0, 5'd0, 16'd0);
        applyStimulus(0, 1, mk(2, 4, 3, 2, 0), 16'h0108, 0, 0, 5'd0, 16'd0);
        chk("lu_stall", {31'd0, obs_stall}, 32'd1);
        chk("lu_bubble", {31'd0, valid_out}, 32'd0);
        applyStimulus(0, 1, mk(2, 4, 3, 2, 0), 16'h0108, 0, 0, 5'd0, 16'd0);
        chk("lu_no_stall", {31'd0, obs_stall}, 32'd0);
        chk("lu_issue", {31'd0, valid_out}, 32'd1);
        chk("lu_issue_ctrl", {27'd0, control_out}, 32'd2);

        // Flush beats a pending load-use stall
        applyStimulus(0, 1, mk(7, 3, 1, 0, 4), 16'h010A, 0, 0, 5'd0, 16'd0);
        applyStimulus(0, 1, mk(2, 4, 3, 2, 0), 16'h010C, 1, 0, 5'd0, 16'd0);
        chk("flush_stall", {31'd0, obs_stall}, 32'd0);
        chk("flush_bubble", {31'd0, valid_out}, 32'd0);

        // Flush squashes a valid ADD
        applyStimulus(0, 1, mk(2, 5, 1, 2, 9), 16'h010E, 1, 0, 5'd0, 16'd0);
        chk("flush_ctrl", {27'd0, control_out}, 32'd0);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);

        // Randomized traffic; fetch holds the instruction while stalled
        r_ins = 32'd0;
        r_pc  = 16'd0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                r_ins = mk($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 127));
                r_pc  = 16'($urandom);
            end
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85), r_ins, r_pc,
                          ($urandom_range(0, 99) < 8), ($urandom_range(0, 1) == 1),
                          5'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
